// File: rtl/tc_psum_drain.sv
// Row-buffering drain stage behind the partial-sum accumulator: captures full rows into a
// small FIFO and serializes them as LANES-wide tagged beats. Optional macro: TC_DRAIN_RELU_EN.
module tc_psum_drain #(
    parameter int unsigned N       = 16,
    parameter int unsigned DW_DATA = 8,
    parameter int unsigned ROWS    = 16,
    parameter int unsigned LANES   = 4,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tile_start,
    input  logic                        in_valid,
    input  logic [N*DW_DATA-1:0]        in_data,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [LANES*DW_DATA-1:0]    out_data,
    output logic [7:0]                  out_row,
    output logic [7:0]                  out_beat,
    output logic                        out_last,
    output logic                        overflow,
    output logic [$clog2(DEPTH):0]      level
);

    localparam int unsigned ROW_W  = N * DW_DATA;
    localparam int unsigned BEAT_W = LANES * DW_DATA;
    localparam int unsigned NBEATS = N / LANES;
    localparam int unsigned CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned PW     = AW + 1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_SEND  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [PW-1:0]   level_q, level_d;
    logic [CW-1:0]   beat_q, beat_d;
    logic [7:0]      row_q, row_d;
    logic            ovf_q, ovf_d;

    logic [ROW_W-1:0] mem_data_q [DEPTH];
    logic [7:0]       mem_tag_q  [DEPTH];

    logic             full_c, beat_fire_c, last_beat_c, pop_c, room_c, push_c, drop_c;
    logic [7:0]       tag_c, tag_inc_c;
    logic [ROW_W-1:0] head_c;
    logic [BEAT_W-1:0] beat_data_c;

    // Handshake and FIFO occupancy decisions for the coming edge
    always_comb begin
        full_c      = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
        beat_fire_c = (state_q == ST_SEND) && out_ready;
        last_beat_c = (beat_q == CW'(NBEATS - 1));
        pop_c       = beat_fire_c && last_beat_c;
        room_c      = !full_c || pop_c;
        push_c      = in_valid && room_c;
        drop_c      = in_valid && !room_c;
        tag_c       = tile_start ? 8'd0 : row_q;
        tag_inc_c   = (tag_c == 8'(ROWS - 1)) ? 8'd0 : tag_c + 8'd1;
    end

    // Next-state logic; a dropped row still advances the tag counter
    always_comb begin
        wptr_d  = wptr_q + PW'(push_c);
        rptr_d  = rptr_q + PW'(pop_c);
        level_d = level_q + PW'(push_c) - PW'(pop_c);
        beat_d  = beat_q;
        if (beat_fire_c) begin
            beat_d = last_beat_c ? '0 : beat_q + CW'(1);
        end
        row_d   = in_valid ? tag_inc_c : tag_c;
        ovf_d   = (ovf_q && !tile_start) || drop_c;
        state_d = (level_d != '0) ? ST_SEND : ST_EMPTY;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            beat_q  <= '0;
            row_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            beat_q  <= beat_d;
            row_q   <= row_d;
            ovf_q   <= ovf_d;
        end
    end

    // Row storage is intentionally left unreset
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_data_q[wptr_q[AW-1:0]] <= in_data;
            mem_tag_q[wptr_q[AW-1:0]]  <= tag_c;
        end
    end

    // Beat select from the head row; optional clamp on the output side only
    always_comb begin
        head_c      = mem_data_q[rptr_q[AW-1:0]];
        beat_data_c = '0;
        for (int b = 0; b < int'(NBEATS); b++) begin
            if (beat_q == CW'(b)) begin
                beat_data_c = head_c[b*BEAT_W +: BEAT_W];
            end
        end
`ifdef TC_DRAIN_RELU_EN
        for (int e = 0; e < int'(LANES); e++) begin
            if (beat_data_c[e*DW_DATA + DW_DATA - 1]) begin
                beat_data_c[e*DW_DATA +: DW_DATA] = '0;
            end
        end
`endif
    end

    always_comb begin
        out_valid = (state_q == ST_SEND);
        out_data  = out_valid ? beat_data_c : '0;
        out_row   = out_valid ? mem_tag_q[rptr_q[AW-1:0]] : 8'd0;
        out_beat  = out_valid ? 8'(beat_q) : 8'd0;
        out_last  = out_valid && last_beat_c && (out_row == 8'(ROWS - 1));
        overflow  = ovf_q;
        level     = level_q;
    end

endmodule

// File: tb/tb_tc_psum_drain.sv
// Self-checking bench for tc_psum_drain against a queue-based row/beat reference model.
module tb_tc_psum_drain;

    localparam int unsigned N     = 16;
    localparam int unsigned DW    = 8;
    localparam int unsigned ROWS  = 16;
    localparam int unsigned LANES = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned NB    = N / LANES;
    localparam int unsigned RW    = N * DW;
    localparam int unsigned BW    = LANES * DW;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;
    localparam int unsigned OW    = 1 + BW + 8 + 8 + 1 + 1 + LW;

    typedef logic [OW-1:0] obs_t;
    typedef struct packed {
        logic [RW-1:0] data;
        logic [7:0]    tag;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          tile_start;
    logic          in_valid;
    logic [RW-1:0] in_data;
    logic          out_ready;
    logic          out_valid;
    logic [BW-1:0] out_data;
    logic [7:0]    out_row;
    logic [7:0]    out_beat;
    logic          out_last;
    logic          overflow;
    logic [LW-1:0] level;

    ent_t mq[$];
    int   mbeat;
    int   mrow;
    logic movf;
    int   n_chk;
    int   n_fail;

    always #5 clk = ~clk;

    tc_psum_drain #(.N(N), .DW_DATA(DW), .ROWS(ROWS), .LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .tile_start(tile_start), .in_valid(in_valid), .in_data(in_data),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .out_row(out_row),
        .out_beat(out_beat), .out_last(out_last), .overflow(overflow), .level(level)
    );

    function automatic obs_t dut_obs();
        return {out_valid, out_data, out_row, out_beat, out_last, overflow, level};
    endfunction

    // What the outputs must show given the rows currently held
    function automatic obs_t model_obs();
        logic          v;
        logic [BW-1:0] d;
        logic [7:0]    r;
        logic [7:0]    b;
        logic          l;
        logic [RW-1:0] hd;
        v = (mq.size() != 0);
        d = '0; r = 8'd0; b = 8'd0; l = 1'b0;
        if (v) begin
            hd = mq[0].data;
            d  = hd[mbeat*BW +: BW];
`ifdef TC_DRAIN_RELU_EN
            for (int e = 0; e < int'(LANES); e++)
                if ($signed(d[e*DW +: DW]) < 0) d[e*DW +: DW] = '0;
`endif
            r = mq[0].tag;
            b = 8'(mbeat);
            l = (mbeat == int'(NB) - 1) && (int'(r) == int'(ROWS) - 1);
        end
        return {v, d, r, b, l, movf, LW'(mq.size())};
    endfunction

    function automatic logic [RW-1:0] rand_row();
        logic [RW-1:0] r;
        for (int e = 0; e < int'(N); e++) r[e*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        mbeat = 0;
        mrow  = 0;
        movf  = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model by one edge, return at the next falling edge
    task automatic step(input logic ts, input logic iv, input logic [RW-1:0] d, input logic rdy);
        logic pop;
        logic room;
        int   tag;
        ent_t en;
        tile_start = ts;
        in_valid   = iv;
        in_data    = d;
        out_ready  = rdy;
        pop  = (mq.size() != 0) && rdy && (mbeat == int'(NB) - 1);
        room = (mq.size() < int'(DEPTH)) || pop;
        tag  = ts ? 0 : mrow;
        if ((mq.size() != 0) && rdy) begin
            if (mbeat == int'(NB) - 1) begin
                mbeat = 0;
                void'(mq.pop_front());
            end else begin
                mbeat++;
            end
        end
        if (ts) movf = 1'b0;
        if (iv) begin
            if (room) begin
                en.data = d;
                en.tag  = 8'(tag);
                mq.push_back(en);
            end else begin
                movf = 1'b1;
            end
            mrow = (tag + 1) % int'(ROWS);
        end else begin
            mrow = tag;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; tile_start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        n_chk++;
        if (dut_obs() !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: dut=%h exp=%h", dut_obs(), obs_t'(0));
        end
        rst = 1'b1;
        step(1'b0, 1'b0, '0, 1'b0);
        n_chk++;
        if (dut_obs() !== model_obs()) begin
            n_fail++;
            $display("FAIL reset_idle: dut=%h exp=%h", dut_obs(), model_obs());
        end
    endtask

    task automatic test_single_row();
        logic [RW-1:0] row;
        for (int e = 0; e < int'(N); e++) row[e*DW +: DW] = DW'(e + 1);
        step(1'b0, 1'b1, row, 1'b1);
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== 32'h04030201 || out_row !== 8'd0 || out_beat !== 8'd0) begin
            n_fail++;
            $display("FAIL single_beat0: valid=%b data=%h row=%0d beat=%0d exp 1/04030201/0/0",
                     out_valid, out_data, out_row, out_beat);
        end
        for (int b = 1; b < int'(NB); b++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            n_chk++;
            if (dut_obs() !== model_obs() || out_beat !== 8'(b)) begin
                n_fail++;
                $display("FAIL single_beat%0d: dut=%h exp=%h", b, dut_obs(), model_obs());
            end
        end
        step(1'b0, 1'b0, '0, 1'b1);
        n_chk++;
        if (level !== LW'(0) || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drained: level=%0d valid=%b exp 0/0", level, out_valid);
        end
    endtask

    task automatic test_tile_wrap();
        int lastcnt;
        lastcnt = 0;
        step(1'b1, 1'b0, '0, 1'b1);
        for (int r = 0; r <= int'(ROWS); r++) begin
            step(1'b0, 1'b1, rand_row(), 1'b1);
            n_chk++;
            if (dut_obs() !== model_obs() || out_row !== 8'(r % int'(ROWS))) begin
                n_fail++;
                $display("FAIL wrap_tag r=%0d: dut=%h exp=%h", r, dut_obs(), model_obs());
            end
            for (int b = 1; b < int'(NB); b++) begin
                step(1'b0, 1'b0, '0, 1'b1);
                n_chk++;
                if (dut_obs() !== model_obs()) begin
                    n_fail++;
                    $display("FAIL wrap_beat r=%0d: dut=%h exp=%h", r, dut_obs(), model_obs());
                end
                if (out_last) lastcnt++;
            end
        end
        step(1'b0, 1'b0, '0, 1'b1);
        n_chk++;
        if (lastcnt != 1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_last: last_count=%0d valid=%b exp 1/0", lastcnt, out_valid);
        end
    endtask

    task automatic test_overflow();
        int k;
        step(1'b1, 1'b1, rand_row(), 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, rand_row(), 1'b0);
        n_chk++;
        if (level !== LW'(4) || overflow !== 1'b1 || dut_obs() !== model_obs()) begin
            n_fail++;
            $display("FAIL ovf_full: level=%0d ovf=%b exp 4/1", level, overflow);
        end
        k = 0;
        for (int i = 0; i < int'(DEPTH * NB); i++) begin
            n_chk++;
            if (dut_obs() !== model_obs() || (out_beat == 8'd0 && out_row !== 8'(k))) begin
                n_fail++;
                $display("FAIL ovf_drain i=%0d: dut=%h exp=%h", i, dut_obs(), model_obs());
            end
            if (out_beat == 8'd0) k++;
            step(1'b0, 1'b0, '0, 1'b1);
        end
        step(1'b0, 1'b1, rand_row(), 1'b1);
        n_chk++;
        if (out_row !== 8'd5 || dut_obs() !== model_obs()) begin
            n_fail++;
            $display("FAIL ovf_next_tag: row=%0d exp 5", out_row);
        end
        for (int i = 0; i < int'(NB); i++) step(1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic test_full_pop();
        step(1'b1, 1'b1, rand_row(), 1'b0);
        for (int i = 0; i < int'(DEPTH) - 1; i++) step(1'b0, 1'b1, rand_row(), 1'b0);
        for (int i = 0; i < int'(NB) - 1; i++) step(1'b0, 1'b0, '0, 1'b1);
        n_chk++;
        if (out_beat !== 8'(NB - 1) || level !== LW'(DEPTH) || dut_obs() !== model_obs()) begin
            n_fail++;
            $display("FAIL fullpop_setup: beat=%0d level=%0d", out_beat, level);
        end
        step(1'b0, 1'b1, rand_row(), 1'b1);
        n_chk++;
        if (level !== LW'(DEPTH) || overflow !== 1'b0 || dut_obs() !== model_obs()) begin
            n_fail++;
            $display("FAIL fullpop_accept: level=%0d ovf=%b exp 4/0", level, overflow);
        end
        for (int i = 0; i < int'(DEPTH * NB); i++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            n_chk++;
            if (dut_obs() !== model_obs()) begin
                n_fail++;
                $display("FAIL fullpop_drain i=%0d: dut=%h exp=%h", i, dut_obs(), model_obs());
            end
        end
    endtask

    task automatic test_relu();
        logic [RW-1:0] row;
        logic [BW-1:0] exp_d;
        row = '0;
        row[0*DW +: DW] = 8'h80;
        row[1*DW +: DW] = 8'h7F;
        row[2*DW +: DW] = 8'hFF;
        row[3*DW +: DW] = 8'h00;
`ifdef TC_DRAIN_RELU_EN
        exp_d = 32'h00007F00;
`else
        exp_d = 32'h00FF7F80;
`endif
        step(1'b0, 1'b1, row, 1'b1);
        n_chk++;
        if (out_data !== exp_d || dut_obs() !== model_obs()) begin
            n_fail++;
            $display("FAIL relu_beat: data=%h exp %h", out_data, exp_d);
        end
        for (int i = 1; i < int'(NB); i++) step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, rand_row(), 1'($urandom_range(0, 1)));
            n_chk++;
            if (dut_obs() !== model_obs()) begin
                n_fail++;
                $display("FAIL b2b_burst i=%0d: dut=%h exp=%h", i, dut_obs(), model_obs());
            end
        end
        for (int i = 0; i < int'(DEPTH * NB) + 2; i++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            n_chk++;
            if (dut_obs() !== model_obs()) begin
                n_fail++;
                $display("FAIL b2b_drain i=%0d: dut=%h exp=%h", i, dut_obs(), model_obs());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 99) < 45),
                 rand_row(), 1'($urandom_range(0, 99) < 70));
            n_chk++;
            if (dut_obs() !== model_obs()) begin
                n_fail++;
                $display("FAIL random i=%0d: dut=%h exp=%h", i, dut_obs(), model_obs());
            end
        end
        for (int i = 0; i < int'(DEPTH * NB) + 2; i++) step(1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, rand_row(), 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        n_chk++;
        if (out_beat !== 8'd2 || overflow !== 1'b1 || dut_obs() !== model_obs()) begin
            n_fail++;
            $display("FAIL areset_setup: beat=%0d ovf=%b exp 2/1", out_beat, overflow);
        end
        #2 rst = 1'b0;
        #1;
        model_reset();
        n_chk++;
        if (out_valid !== 1'b0 || level !== LW'(0) || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_immediate: valid=%b level=%0d ovf=%b exp 0/0/0", out_valid, level, overflow);
        end
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b0, '0, 1'b1);
        n_chk++;
        if (dut_obs() !== model_obs()) begin
            n_fail++;
            $display("FAIL areset_idle: dut=%h exp=%h", dut_obs(), model_obs());
        end
        step(1'b0, 1'b1, rand_row(), 1'b1);
        n_chk++;
        if (out_row !== 8'd0 || dut_obs() !== model_obs()) begin
            n_fail++;
            $display("FAIL areset_first_tag: row=%0d exp 0", out_row);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_single_row();
        test_tile_wrap();
        test_overflow();
        test_full_pop();
        test_relu();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/tc_psum_drain.md
# tc_psum_drain

Output drain stage placed directly downstream of the partial-sum accumulator (`tc_psum`). It captures each full accumulator row (N elements) presented on a valid strobe that carries no backpressure, buffers rows in a small FIFO, and serializes them to a narrower LANES-wide output bus with a valid/ready handshake. Each output beat is tagged with row and column-group indices, and the final beat of a tile is marked. The block absorbs the accumulator's burst drain and lets the writeback path stall without losing data, up to the FIFO depth.

## Interface
Parameters:
- `N`, 16: elements per accumulator row; must be a multiple of `LANES`.
- `DW_DATA`, 8: element width in bits, two's complement.
- `ROWS`, 16: rows per tile; the row tag wraps after `ROWS-1`.
- `LANES`, 4: elements per output beat.
- `DEPTH`, 4: FIFO depth in rows; must be a power of two, ≥ 2.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `tile_start`, in, 1: one-cycle pulse; clears the row counter and the `overflow` flag.
- `in_valid`, in, 1: a row is present on `in_data` this cycle.
- `in_data`, in, N*DW_DATA: row data; element e occupies bits [e*DW_DATA +: DW_DATA].
- `out_ready`, in, 1: downstream accepts the current beat.
- `out_valid`, out, 1: a beat is available.
- `out_data`, out, LANES*DW_DATA: elements [beat*LANES +: LANES] of the head row.
- `out_row`, out, 8: row index of the head row.
- `out_beat`, out, 8: column-group index, 0 … N/LANES-1.
- `out_last`, out, 1: last beat of row `ROWS-1`.
- `overflow`, out, 1: sticky flag; set when a row was dropped.
- `level`, out, $clog2(DEPTH)+1: number of rows currently held.

## Operation
- FIFO contents: `DEPTH` entries, each holding the row data and an 8-bit row tag. Pointers carry one extra wrap bit.
  - Empty when the pointers are equal.
  - Full when the indices match and the wrap bits differ.
- Push: when `in_valid`=1 and there is room, the entry is written with `in_data` and tag = `row_cnt`.
  - `row_cnt` then increments, wrapping from `ROWS-1` to 0.
  - There is room if the FIFO is not full, or if it is full and a row-completing pop happens in the same cycle.
- Drop: when `in_valid`=1 with no room, the row is discarded, `overflow` is set, and `row_cnt` still increments so later tags stay aligned.
- Output (two states):
  - `EMPTY`: `out_valid`=0.
  - `SEND`: `out_valid`=1; `out_data`, `out_row` and `out_beat` are driven combinationally from the head entry and the beat counter.
- Beat completion: a beat completes when `out_valid && out_ready`.
  - `beat_cnt` increments on each completed beat.
  - On beat `N/LANES-1`, `beat_cnt` returns to 0 and the head row pops.
- `out_last` = `out_valid` && beat = `N/LANES-1` && `out_row` = `ROWS-1`.
- `tile_start`:
  - Clears `row_cnt` and `overflow`.
  - Does not flush the FIFO.
  - If it arrives together with `in_valid`, the pushed row gets tag 0.
- Data is passed through unmodified unless `TC_DRAIN_RELU_EN` is defined.
- While `out_ready`=0, the outputs hold stable.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_row`=0, `out_beat`=0, `out_last`=0, `overflow`=0, `level`=0.
  - Pointers, `row_cnt` and `beat_cnt` are 0.
  - FIFO storage is not reset.
- Latency: a row accepted at edge k produces `out_valid`=1 in the cycle after edge k. The first beat can complete at edge k+1.
- Throughput: with `out_ready` held high, one beat per cycle, so one row per N/LANES cycles.
  - The upstream drain delivers one row per cycle, so a burst longer than `DEPTH` plus the rows consumed during the burst overflows.
- `level` updates on the same edge as a push or pop. A simultaneous push and pop leaves `level` unchanged.
- Reset asserted mid-transfer: all state clears immediately and in-flight rows are lost. The first edge after reset release behaves as post-reset idle.

## Configuration
- `TC_DRAIN_RELU_EN` defined: each element of `out_data` is forced to 0 when its sign bit is 1. Clamping is applied on the output mux, so FIFO contents stay raw.
- `TC_DRAIN_RELU_EN` undefined: elements pass through bit-exact. No clamp logic is synthesized.

## Test plan
- Single row, always ready: N=16, LANES=4; push row with elements 0x01…0x10, `out_ready`=1.
  - Expect 4 consecutive beats with `out_beat` 0–3; beat 0 data = {0x04,0x03,0x02,0x01}; `out_row`=0; `level` returns to 0.
- Tile wrap: push 16 rows over time, with `out_ready`=1.
  - Expect tags 0–15; `out_last`=1 only on beat 3 of row 15.
  - A 17th row gets tag 0.
- Backpressure and overflow: `out_ready`=0; push 5 rows back-to-back with DEPTH=4.
  - Expect `level`=4 and `overflow`=1; rows 0–3 are retained and drain in order once ready rises.
  - The next pushed row gets tag 5.
- Full with simultaneous pop: FIFO full, `out_ready`=1 on beat 3 of the head row, `in_valid`=1 in the same cycle.
  - Expect the row to be accepted, `overflow` to stay 0, and `level` to stay 4.
- Async reset mid-row: assert `rst`=0 between edges during beat 2.
  - Expect `out_valid`, `level` and `overflow` to be 0 immediately, before the next edge.
- With `TC_DRAIN_RELU_EN` defined: push elements 0x80, 0x7F, 0xFF, 0x00.
  - Expect the beat to read 0x00, 0x7F, 0x00, 0x00.
